bank_sram_relu_pipe: RTL and testbench

Multi-bank, multi-stream scratch SRAM for the EPU ReLU stage: M request streams reach NB single-port banks through per-bank round-robin arbiters. This generation adds a configurable read latency, per-request tags returned with read data, an optional ReLU applied on write or on read, and a saturating bank-conflict counter. It sits between the TPU result drain and the ReLU/store path, replacing the fixed 1-cycle banked SRAM.

---
 rtl/relu_epu_pkg.sv | 22 ++
 rtl/rr_arbiter_relu.sv | 39 +++
 rtl/bank_sram_relu_pipe.sv | 176 +++++++++++++++++
 tb/tb_bank_sram_relu_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_epu_pkg.sv
// Shared helpers for the banked ReLU scratch SRAM: width math and the ReLU zeroing rule.
package relu_epu_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bank_w(input int nb);
    return (clog2(nb) < 1) ? 1 : clog2(nb);
  endfunction

  // ReLU zeroes a word when its sign bit is set; this covers ints, floats and -0.0 alike.
  function automatic logic relu_zero(input logic msb, input logic en);
    return msb & en;
  endfunction

endpackage

// File: rtl/rr_arbiter_relu.sv
// Round-robin arbiter: one-hot grant, priority rotates to the stream after the last winner.
module rr_arbiter_relu
  import relu_epu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any_gnt
);

  localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    ptr_d   = ptr_q;
    for (int i = 0; i < N; i++) begin : g_scan
      logic [PW-1:0] idx;
      idx = PW'((int'(ptr_q) + i) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        any_gnt  = 1'b1;
        ptr_d    = PW'((int'(ptr_q) + i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bank_sram_relu_pipe.sv
// Multi-stream banked scratch SRAM with per-bank RR arbitration, tagged reads,
// configurable read latency, ReLU on write or read, and a saturating conflict counter.
module bank_sram_relu_pipe
  import relu_epu_pkg::*;
#(
  parameter int NB     = 8,
  parameter int M      = 8,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [M-1:0]        req_v,
  input  logic [M-1:0]        req_we,
  input  logic [M-1:0]        req_relu,
  input  logic [M*ADDR_W-1:0] req_addr,
  input  logic [M*DATA_W-1:0] req_wdata,
  input  logic [M*TAG_W-1:0]  req_tag,
  output logic [M-1:0]        req_ready,
  output logic [M-1:0]        rsp_v,
  output logic [M*DATA_W-1:0] rsp_rdata,
  output logic [M*TAG_W-1:0]  rsp_tag,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    conf_cnt
);

  localparam int BANK_W = bank_w(NB);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = 1 << ROW_W;
  localparam int SW     = (clog2(M) < 1) ? 1 : clog2(M);

  // Handshake: a request transfers in the cycle req_v & req_ready; req_ready is
  // combinational and a stream that is not granted must hold all fields stable.
  logic [BANK_W-1:0] s_bank [M];
  logic [ROW_W-1:0]  s_row  [M];

  logic [M-1:0]      bank_req  [NB];
  logic [M-1:0]      bank_gnt  [NB];
  logic [NB-1:0]     bank_any;
  logic [NB-1:0]     bank_v;
  logic [SW-1:0]     bank_sel  [NB];
  logic [DATA_W-1:0] bank_data [NB];
  logic [TAG_W-1:0]  bank_tag  [NB];

  for (genvar m = 0; m < M; m++) begin : g_dec
    assign s_bank[m] = req_addr[m*ADDR_W +: BANK_W];
    assign s_row[m]  = req_addr[m*ADDR_W+BANK_W +: ROW_W];
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic              g_we;
    logic              g_relu;
    logic [SW-1:0]     g_sel;
    logic [ROW_W-1:0]  g_row;
    logic [DATA_W-1:0] g_wdata;
    logic [TAG_W-1:0]  g_tag;
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] dpipe_q [RD_LAT];
    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] relu_q;
    logic [SW-1:0]     sel_q [RD_LAT];
    logic [TAG_W-1:0]  tag_q [RD_LAT];

    for (genvar m = 0; m < M; m++) begin : g_req
      assign bank_req[b][m] = req_v[m] && (s_bank[m] == BANK_W'(b));
    end

    rr_arbiter_relu #(.N(M)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bank_req[b]),
      .gnt     (bank_gnt[b]),
      .any_gnt (bank_any[b])
    );

    always_comb begin
      g_we    = 1'b0;
      g_relu  = 1'b0;
      g_sel   = '0;
      g_row   = '0;
      g_wdata = '0;
      g_tag   = '0;
      for (int m = 0; m < M; m++) begin
        if (bank_gnt[b][m]) begin
          g_we    = req_we[m];
          g_relu  = req_relu[m];
          g_sel   = SW'(m);
          g_row   = s_row[m];
          g_wdata = req_wdata[m*DATA_W +: DATA_W];
          g_tag   = req_tag[m*TAG_W +: TAG_W];
        end
      end
    end

    // Storage and read data path carry no reset; validity lives in the sideband pipe.
    always_ff @(posedge clk) begin
      if (bank_any[b] && g_we) begin
        mem[g_row] <= relu_zero(g_wdata[DATA_W-1], g_relu) ? '0 : g_wdata;
      end
      if (bank_any[b] && !g_we) dpipe_q[0] <= mem[g_row];
      for (int s = 1; s < RD_LAT; s++) dpipe_q[s] <= dpipe_q[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= '0;
        relu_q <= '0;
        for (int s = 0; s < RD_LAT; s++) begin
          sel_q[s] <= '0;
          tag_q[s] <= '0;
        end
      end else begin
        v_q[0]    <= bank_any[b] & ~g_we;
        relu_q[0] <= g_relu;
        sel_q[0]  <= g_sel;
        tag_q[0]  <= g_tag;
        for (int s = 1; s < RD_LAT; s++) begin
          v_q[s]    <= v_q[s-1];
          relu_q[s] <= relu_q[s-1];
          sel_q[s]  <= sel_q[s-1];
          tag_q[s]  <= tag_q[s-1];
        end
      end
    end

    assign bank_v[b]    = v_q[RD_LAT-1];
    assign bank_sel[b]  = sel_q[RD_LAT-1];
    assign bank_tag[b]  = tag_q[RD_LAT-1];
    assign bank_data[b] = relu_zero(dpipe_q[RD_LAT-1][DATA_W-1], relu_q[RD_LAT-1]) ?
                          '0 : dpipe_q[RD_LAT-1];
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NB; b++) req_ready = req_ready | bank_gnt[b];
  end

  // A stream holds at most one grant per cycle, so at most one bank answers it.
  always_comb begin
    rsp_v     = '0;
    rsp_rdata = '0;
    rsp_tag   = '0;
    for (int b = 0; b < NB; b++) begin
      for (int m = 0; m < M; m++) begin
        if (bank_v[b] && (bank_sel[b] == SW'(m))) begin
          rsp_v[m]                      = 1'b1;
          rsp_rdata[m*DATA_W +: DATA_W] = bank_data[b];
          rsp_tag[m*TAG_W +: TAG_W]     = bank_tag[b];
        end
      end
    end
  end

  logic             conflict;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign conflict = |(req_v & ~req_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                       cnt_d = '0;
    else if (conflict && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conf_cnt = cnt_q;

endmodule

// File: tb/tb_bank_sram_relu_pipe.sv
// Directed bench: two instances (read latency 1 / 16-bit counter, read latency 3 / 4-bit counter) share stimulus.
module tb_bank_sram_relu_pipe;

  localparam int NB = 8, M = 8, ADDR_W = 12, DATA_W = 32, TAG_W = 4;

  logic                clk, rst, cnt_clr;
  logic [M-1:0]        req_v, req_we, req_relu;
  logic [M*ADDR_W-1:0] req_addr;
  logic [M*DATA_W-1:0] req_wdata;
  logic [M*TAG_W-1:0]  req_tag;
  logic [M-1:0]        ready1, ready3, rsp_v1, rsp_v3;
  logic [M*DATA_W-1:0] rdata1, rdata3;
  logic [M*TAG_W-1:0]  tag1, tag3;
  logic [15:0]         cnt1;
  logic [3:0]          cnt3;
  int                  n_tests, n_fail;

  bank_sram_relu_pipe #(.NB(NB), .M(M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                        .RD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst(rst), .req_v(req_v), .req_we(req_we), .req_relu(req_relu),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag), .req_ready(ready1),
    .rsp_v(rsp_v1), .rsp_rdata(rdata1), .rsp_tag(tag1), .cnt_clr(cnt_clr), .conf_cnt(cnt1)
  );

  bank_sram_relu_pipe #(.NB(NB), .M(M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                        .RD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst(rst), .req_v(req_v), .req_we(req_we), .req_relu(req_relu),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag), .req_ready(ready3),
    .rsp_v(rsp_v3), .rsp_rdata(rdata3), .rsp_tag(tag3), .cnt_clr(cnt_clr), .conf_cnt(cnt3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_v = '0; req_we = '0; req_relu = '0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
  endtask

  task automatic set_req(input int m, input logic we, input logic relu, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] tag);
    req_v[m]                = 1'b1;
    req_we[m]               = we;
    req_relu[m]             = relu;
    req_addr[m*ADDR_W +: ADDR_W] = addr;
    req_wdata[m*DATA_W +: DATA_W] = wdata;
    req_tag[m*TAG_W +: TAG_W]     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_clr = 1'b0; clear_reqs();
    @(negedge clk);
    n_tests++; if (rsp_v1 !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_v1: got %h expected 00", rsp_v1); end
    n_tests++; if (rsp_v3 !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_v3: got %h expected 00", rsp_v3); end
    n_tests++; if (rdata1 !== '0) begin n_fail++; $display("FAIL rst_rdata1: got %h expected 0", rdata1); end
    n_tests++; if (tag3 !== '0) begin n_fail++; $display("FAIL rst_tag3: got %h expected 0", tag3); end
    n_tests++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL rst_cnt1: got %0d expected 0", cnt1); end
    n_tests++; if (cnt3 !== 4'd0) begin n_fail++; $display("FAIL rst_cnt3: got %0d expected 0", cnt3); end
    n_tests++; if (ready1 !== 8'h00) begin n_fail++; $display("FAIL rst_ready_idle: got %h expected 00", ready1); end
    set_req(2, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    n_tests++; if (ready1 !== 8'h04) begin n_fail++; $display("FAIL rst_ready_comb: got %h expected 04", ready1); end
    clear_reqs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    set_req(3, 1'b1, 1'b0, 12'h015, 32'h3F80_0000, 4'h0);
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h08) begin n_fail++; $display("FAIL wr_ready: got %h expected 08", ready1); end
    step();
    clear_reqs();
    set_req(3, 1'b0, 1'b0, 12'h015, 32'h0, 4'h5);
    @(negedge clk);
    n_tests++; if (rsp_v1 !== 8'h00) begin n_fail++; $display("FAIL wr_no_rsp: got %h expected 00", rsp_v1); end
    step();
    clear_reqs();
    @(negedge clk);
    n_tests++; if (rsp_v1 !== 8'h08) begin n_fail++; $display("FAIL rd_rsp_v1: got %h expected 08", rsp_v1); end
    n_tests++; if (rdata1[3*DATA_W +: DATA_W] !== 32'h3F80_0000) begin n_fail++; $display("FAIL rd_data1: got %h expected 3f800000", rdata1[3*DATA_W +: DATA_W]); end
    n_tests++; if (tag1[3*TAG_W +: TAG_W] !== 4'h5) begin n_fail++; $display("FAIL rd_tag1: got %h expected 5", tag1[3*TAG_W +: TAG_W]); end
    n_tests++; if (rsp_v3 !== 8'h00) begin n_fail++; $display("FAIL rd_early_v3: got %h expected 00", rsp_v3); end
    step();
    @(negedge clk);
    n_tests++; if (rsp_v1 !== 8'h00) begin n_fail++; $display("FAIL rd_one_cycle_v1: got %h expected 00", rsp_v1); end
    n_tests++; if (rdata1 !== '0) begin n_fail++; $display("FAIL rd_idle_data1: got %h expected 0", rdata1); end
    step();
    @(negedge clk);
    n_tests++; if (rsp_v3 !== 8'h08) begin n_fail++; $display("FAIL rd_rsp_v3: got %h expected 08", rsp_v3); end
    n_tests++; if (rdata3[3*DATA_W +: DATA_W] !== 32'h3F80_0000) begin n_fail++; $display("FAIL rd_data3: got %h expected 3f800000", rdata3[3*DATA_W +: DATA_W]); end
    n_tests++; if (tag3[3*TAG_W +: TAG_W] !== 4'h5) begin n_fail++; $display("FAIL rd_tag3: got %h expected 5", tag3[3*TAG_W +: TAG_W]); end
    step();
    @(negedge clk);
    n_tests++; if (rsp_v3 !== 8'h00) begin n_fail++; $display("FAIL rd_one_cycle_v3: got %h expected 00", rsp_v3); end
    step();
  endtask

  task automatic test_relu();
    int          rm [4] = '{1, 6, 6, 4};
    logic [11:0] ra [4] = '{12'h021, 12'h032, 12'h032, 12'h015};
    logic        rr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] re [4] = '{32'h0, 32'h0, 32'hC000_0000, 32'h3F80_0000};
    logic [7:0]  exp_v;
    set_req(1, 1'b1, 1'b1, 12'h021, 32'hBF80_0000, 4'h0);
    set_req(6, 1'b1, 1'b0, 12'h032, 32'hC000_0000, 4'h0);
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h42) begin n_fail++; $display("FAIL relu_wr_ready: got %h expected 42", ready1); end
    step();
    for (int i = 0; i < 4; i++) begin
      clear_reqs();
      set_req(rm[i], 1'b0, rr[i], ra[i], 32'h0, 4'(i + 1));
      exp_v = '0; exp_v[rm[i]] = 1'b1;
      step();
      clear_reqs();
      @(negedge clk);
      n_tests++; if (rsp_v1 !== exp_v) begin n_fail++; $display("FAIL relu_v1[%0d]: got %h expected %h", i, rsp_v1, exp_v); end
      n_tests++; if (rdata1[rm[i]*DATA_W +: DATA_W] !== re[i]) begin n_fail++; $display("FAIL relu_data1[%0d]: got %h expected %h", i, rdata1[rm[i]*DATA_W +: DATA_W], re[i]); end
      n_tests++; if (tag1[rm[i]*TAG_W +: TAG_W] !== 4'(i + 1)) begin n_fail++; $display("FAIL relu_tag1[%0d]: got %h expected %h", i, tag1[rm[i]*TAG_W +: TAG_W], 4'(i + 1)); end
      step();
      step();
      @(negedge clk);
      n_tests++; if (rsp_v3 !== exp_v) begin n_fail++; $display("FAIL relu_v3[%0d]: got %h expected %h", i, rsp_v3, exp_v); end
      n_tests++; if (rdata3[rm[i]*DATA_W +: DATA_W] !== re[i]) begin n_fail++; $display("FAIL relu_data3[%0d]: got %h expected %h", i, rdata3[rm[i]*DATA_W +: DATA_W], re[i]); end
      step();
    end
  endtask

  task automatic test_conflict();
    rst = 1'b1; clear_reqs();
    step();
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 12'h001, 32'h0, 4'h0);
    set_req(2, 1'b0, 1'b0, 12'h011, 32'h0, 4'h2);
    set_req(5, 1'b0, 1'b0, 12'h021, 32'h0, 4'h5);
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h01) begin n_fail++; $display("FAIL conf_gnt0: got %h expected 01", ready1); end
    n_tests++; if (ready3 !== 8'h01) begin n_fail++; $display("FAIL conf_gnt0_l3: got %h expected 01", ready3); end
    step();
    req_v[0] = 1'b0;
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h04) begin n_fail++; $display("FAIL conf_gnt2: got %h expected 04", ready1); end
    n_tests++; if (rsp_v1 !== 8'h01) begin n_fail++; $display("FAIL conf_rsp0: got %h expected 01", rsp_v1); end
    step();
    req_v[2] = 1'b0;
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h20) begin n_fail++; $display("FAIL conf_gnt5: got %h expected 20", ready1); end
    n_tests++; if (rsp_v1 !== 8'h04) begin n_fail++; $display("FAIL conf_rsp2: got %h expected 04", rsp_v1); end
    n_tests++; if (cnt1 !== 16'd2) begin n_fail++; $display("FAIL conf_cnt_mid: got %0d expected 2", cnt1); end
    step();
    clear_reqs();
    cnt_clr = 1'b1;
    @(negedge clk);
    n_tests++; if (cnt1 !== 16'd2) begin n_fail++; $display("FAIL conf_cnt1: got %0d expected 2", cnt1); end
    n_tests++; if (cnt3 !== 4'd2) begin n_fail++; $display("FAIL conf_cnt3: got %0d expected 2", cnt3); end
    n_tests++; if (rsp_v1 !== 8'h20) begin n_fail++; $display("FAIL conf_rsp5: got %h expected 20", rsp_v1); end
    n_tests++; if (tag1[5*TAG_W +: TAG_W] !== 4'h5) begin n_fail++; $display("FAIL conf_tag5: got %h expected 5", tag1[5*TAG_W +: TAG_W]); end
    step();
    cnt_clr = 1'b0;
    set_req(0, 1'b0, 1'b0, 12'h001, 32'h0, 4'h0);
    set_req(7, 1'b0, 1'b0, 12'h071, 32'h0, 4'h7);
    @(negedge clk);
    n_tests++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL conf_clr: got %0d expected 0", cnt1); end
    n_tests++; if (ready1 !== 8'h80) begin n_fail++; $display("FAIL conf_wrap7: got %h expected 80", ready1); end
    step();
    req_v[7] = 1'b0;
    @(negedge clk);
    n_tests++; if (ready1 !== 8'h01) begin n_fail++; $display("FAIL conf_wrap0: got %h expected 01", ready1); end
    step();
    clear_reqs();
    @(negedge clk);
    n_tests++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL conf_cnt_wrap: got %0d expected 1", cnt1); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    logic [3:0]  exp_t;
    int          bk, r;
    for (int w = 0; w < 4; w++) begin
      clear_reqs();
      for (int m = 0; m < M; m++) set_req(m, 1'b1, 1'b0, 12'(((8 + w) << 3) | m), 32'h1000_0000 + 32'(w << 8) + 32'(m), 4'h0);
      @(negedge clk);
      n_tests++; if (ready1 !== 8'hFF) begin n_fail++; $display("FAIL b2b_wr_ready[%0d]: got %h expected ff", w, ready1); end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      clear_reqs();
      if (k < 4) begin
        for (int m = 0; m < M; m++) begin
          bk = (m + k) % 8;
          set_req(m, 1'b0, 1'b0, 12'(((8 + k) << 3) | bk), 32'h0, 4'((m * 2 + k) & 15));
        end
      end
      @(negedge clk);
      if (k < 4) begin
        n_tests++; if (ready3 !== 8'hFF) begin n_fail++; $display("FAIL b2b_rd_ready[%0d]: got %h expected ff", k, ready3); end
      end
      n_tests++; if (rsp_v1 !== ((k >= 1 && k <= 4) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL b2b_v1[%0d]: got %h", k, rsp_v1); end
      n_tests++; if (rsp_v3 !== ((k >= 3 && k <= 6) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL b2b_v3[%0d]: got %h", k, rsp_v3); end
      for (int m = 0; m < M; m++) begin
        if (k >= 1 && k <= 4) begin
          r = k - 1; bk = (m + r) % 8;
          exp_d = 32'h1000_0000 + 32'(r << 8) + 32'(bk);
          exp_t = 4'((m * 2 + r) & 15);
          n_tests++; if (rdata1[m*DATA_W +: DATA_W] !== exp_d) begin n_fail++; $display("FAIL b2b_d1[%0d][%0d]: got %h expected %h", k, m, rdata1[m*DATA_W +: DATA_W], exp_d); end
          n_tests++; if (tag1[m*TAG_W +: TAG_W] !== exp_t) begin n_fail++; $display("FAIL b2b_t1[%0d][%0d]: got %h expected %h", k, m, tag1[m*TAG_W +: TAG_W], exp_t); end
        end
        if (k >= 3 && k <= 6) begin
          r = k - 3; bk = (m + r) % 8;
          exp_d = 32'h1000_0000 + 32'(r << 8) + 32'(bk);
          exp_t = 4'((m * 2 + r) & 15);
          n_tests++; if (rdata3[m*DATA_W +: DATA_W] !== exp_d) begin n_fail++; $display("FAIL b2b_d3[%0d][%0d]: got %h expected %h", k, m, rdata3[m*DATA_W +: DATA_W], exp_d); end
          n_tests++; if (tag3[m*TAG_W +: TAG_W] !== exp_t) begin n_fail++; $display("FAIL b2b_t3[%0d][%0d]: got %h expected %h", k, m, tag3[m*TAG_W +: TAG_W], exp_t); end
        end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    clear_reqs();
    set_req(0, 1'b0, 1'b0, 12'h003, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 12'h013, 32'h0, 4'h1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    n_tests++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL sat_clr_prio: got %0d expected 0", cnt1); end
    n_tests++; if (cnt3 !== 4'd0) begin n_fail++; $display("FAIL sat_clr_prio3: got %0d expected 0", cnt3); end
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    n_tests++; if (cnt3 !== 4'hF) begin n_fail++; $display("FAIL sat_cnt3: got %h expected f", cnt3); end
    n_tests++; if (cnt1 !== 16'd20) begin n_fail++; $display("FAIL sat_cnt1: got %0d expected 20", cnt1); end
    step();
    clear_reqs();
    step();
  endtask

  task automatic test_reset_midflight();
    clear_reqs();
    for (int m = 0; m < 4; m++) set_req(m, 1'b0, 1'b0, 12'(8'h40 + m), 32'h0, 4'(m));
    @(negedge clk);
    n_tests++; if (ready3 !== 8'h0F) begin n_fail++; $display("FAIL mid_ready: got %h expected 0f", ready3); end
    step();
    clear_reqs();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp_v3 !== 8'h00) begin n_fail++; $display("FAIL mid_in_rst_v3: got %h expected 00", rsp_v3); end
    n_tests++; if (rsp_v1 !== 8'h00) begin n_fail++; $display("FAIL mid_in_rst_v1: got %h expected 00", rsp_v1); end
    n_tests++; if (cnt3 !== 4'd0) begin n_fail++; $display("FAIL mid_cnt3: got %0d expected 0", cnt3); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (rsp_v3 !== 8'h00) begin n_fail++; $display("FAIL mid_after_v3[%0d]: got %h expected 00", i, rsp_v3); end
      n_tests++; if (rdata3 !== '0) begin n_fail++; $display("FAIL mid_after_d3[%0d]: got %h expected 0", i, rdata3); end
      step();
    end
    set_req(0, 1'b0, 1'b0, 12'h040, 32'h0, 4'h0);
    set_req(4, 1'b0, 1'b0, 12'h048, 32'h0, 4'h4);
    @(negedge clk);
    n_tests++; if (ready3 !== 8'h01) begin n_fail++; $display("FAIL mid_ptr_restart: got %h expected 01", ready3); end
    step();
    clear_reqs();
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    cnt_clr = 1'b0;
    clear_reqs();
    test_reset();
    test_write_read();
    test_relu();
    test_conflict();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
